// File: rtl/fpdiv_pkg.sv
// Shared definitions for the fpdiv_scalar divider: quotient digit encoding
// and the remainder-resolve FSM state type.
package fpdiv_pkg;

    // Quotient digit encoding produced by the SRT selection logic.
    // 2'b11 is never a legal digit.
    localparam logic [1:0] QDIG_ZERO = 2'b00;
    localparam logic [1:0] QDIG_POS  = 2'b01;
    localparam logic [1:0] QDIG_NEG  = 2'b10;

    // Remainder-resolve controller states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ITER = 3'd1,
        ST_CPA  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } rr_state_t;

endpackage

// File: rtl/radix_2_otfc.sv
// On-the-fly conversion of signed radix-2 quotient digits into two
// non-redundant candidates: q (the quotient) and qm (the quotient minus one
// ulp). Shifting both left by one digit per update keeps the final choice
// between them a plain select, with no carry propagation at the end.
module radix_2_otfc
    import fpdiv_pkg::*;
#(
    parameter int QUOT_W = 54
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [1:0]        digit,
    output logic [QUOT_W-1:0] q,
    output logic [QUOT_W-1:0] qm
);

    // Shifted candidates; the extra top bit is the MSB that falls off.
    logic [QUOT_W:0]   q_sh0;
    logic [QUOT_W:0]   q_sh1;
    logic [QUOT_W:0]   qm_sh0;
    logic [QUOT_W:0]   qm_sh1;
    logic [QUOT_W-1:0] q_next;
    logic [QUOT_W-1:0] qm_next;

    assign q_sh0  = {q, 1'b0};
    assign q_sh1  = {q, 1'b1};
    assign qm_sh0 = {qm, 1'b0};
    assign qm_sh1 = {qm, 1'b1};

    // Digit-driven update mux; the illegal code falls through as a zero digit.
    always_comb begin
        q_next  = q_sh0[QUOT_W-1:0];
        qm_next = qm_sh1[QUOT_W-1:0];
        case (digit)
            QDIG_POS: begin
                q_next  = q_sh1[QUOT_W-1:0];
                qm_next = q_sh0[QUOT_W-1:0];
            end
            QDIG_NEG: begin
                q_next  = qm_sh1[QUOT_W-1:0];
                qm_next = qm_sh0[QUOT_W-1:0];
            end
            default: begin
                q_next  = q_sh0[QUOT_W-1:0];
                qm_next = qm_sh1[QUOT_W-1:0];
            end
        endcase
    end

    // Q/QM registers: clear wins over a digit update.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q  <= '0;
            qm <= '0;
        end else if (en) begin
            q  <= q_next;
            qm <= qm_next;
        end
    end

endmodule

// File: rtl/radix_2_srt_rem_resolve.sv
// Back end of the radix-2 SRT divider: collects quotient digits through
// on-the-fly conversion, resolves the final redundant remainder with a
// carry-propagate add, corrects a negative remainder by adding the divisor
// back (selecting QM as the quotient), and hands the result downstream.
//
// Handshakes: every channel transfers on the cycle where valid and ready are
// both high at the rising edge. start_ready_o is high only in IDLE,
// digit_ready_o only in ITER, out_valid_o only in DONE; a producer keeps
// valid (and its data) up until the transfer, and the result is held stable
// while out_valid_o is high and out_ready_i is low.
module radix_2_srt_rem_resolve
    import fpdiv_pkg::*;
#(
    parameter int WIDTH    = 66,
    parameter int QUOT_W   = 54,
    parameter int ITER_NUM = QUOT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic [WIDTH-2:0] divisor_i,
    input  logic             digit_valid_i,
    output logic             digit_ready_o,
    input  logic [1:0]       q_digit_i,
    input  logic [WIDTH-2:0] rem_sum_i,
    input  logic [WIDTH-2:0] rem_carry_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [QUOT_W-1:0] quot_o,
    output logic [WIDTH-2:0] rem_o,
    output logic             rem_zero_o,
    output logic             digit_err_o
);

    localparam int CNT_W = $clog2(ITER_NUM + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_NUM - 1);

    rr_state_t         state;
    rr_state_t         state_next;

    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-2:0]  div_r;
    logic [WIDTH-2:0]  sum_r;
    logic [WIDTH-2:0]  carry_r;
    logic [WIDTH-2:0]  rem_r;
    logic              digit_err_r;
    logic [QUOT_W-1:0] q;
    logic [QUOT_W-1:0] qm;

    logic              start_fire;
    logic              digit_fire;
    logic              last_digit;
    logic              rem_neg;

    assign start_fire = start_valid_i && (state == ST_IDLE);
    assign digit_fire = digit_valid_i && (state == ST_ITER);
    assign last_digit = digit_fire && (cnt == CNT_LAST);
    assign rem_neg    = rem_r[WIDTH-2];

    assign start_ready_o = (state == ST_IDLE);
    assign digit_ready_o = (state == ST_ITER);
    assign out_valid_o   = (state == ST_DONE);
    assign digit_err_o   = digit_err_r;

    radix_2_otfc #(
        .QUOT_W (QUOT_W)
    ) u_otfc (
        .clk   (clk),
        .rst   (rst),
        .clear (start_fire),
        .en    (digit_fire),
        .digit (q_digit_i),
        .q     (q),
        .qm    (qm)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: CPA and FIX are single fixed cycles.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_fire) state_next = ST_ITER;
            ST_ITER: if (last_digit) state_next = ST_CPA;
            ST_CPA:  state_next = ST_FIX;
            ST_FIX:  state_next = ST_DONE;
            ST_DONE: if (out_ready_i) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, digit count, remainder resolve and correction.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            div_r       <= '0;
            sum_r       <= '0;
            carry_r     <= '0;
            rem_r       <= '0;
            digit_err_r <= 1'b0;
            quot_o      <= '0;
            rem_o       <= '0;
            rem_zero_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_fire) begin
                        div_r       <= divisor_i;
                        cnt         <= '0;
                        digit_err_r <= 1'b0;
                    end
                end
                ST_ITER: begin
                    if (digit_fire) begin
                        cnt <= cnt + CNT_W'(1);
                        if (q_digit_i == 2'b11) begin
                            digit_err_r <= 1'b1;
                        end
                        // The remainder inputs only mean anything alongside
                        // the final digit.
                        if (last_digit) begin
                            sum_r   <= rem_sum_i;
                            carry_r <= rem_carry_i;
                        end
                    end
                end
                ST_CPA: begin
                    rem_r <= sum_r + carry_r;
                end
                ST_FIX: begin
                    // Zero test looks at the uncorrected remainder: a zero
                    // partial remainder means the division was exact.
                    rem_zero_o <= (rem_r == '0);
                    if (rem_neg) begin
                        rem_r  <= rem_r + div_r;
                        rem_o  <= rem_r + div_r;
                        quot_o <= qm;
                    end else begin
                        rem_o  <= rem_r;
                        quot_o <= q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_radix_2_srt_rem_resolve.sv
// Directed bench for radix_2_srt_rem_resolve at WIDTH=8, QUOT_W=4,
// ITER_NUM=4, divisor 7'h10.
module tb_radix_2_srt_rem_resolve;

    localparam int WIDTH    = 8;
    localparam int QUOT_W   = 4;
    localparam int ITER_NUM = 4;

    localparam logic [1:0] DP = 2'b01;
    localparam logic [1:0] DN = 2'b10;
    localparam logic [1:0] DZ = 2'b00;
    localparam logic [1:0] DX = 2'b11;

    logic             clk;
    logic             rst;
    logic             start_valid_i;
    logic             start_ready_o;
    logic [WIDTH-2:0] divisor_i;
    logic             digit_valid_i;
    logic             digit_ready_o;
    logic [1:0]       q_digit_i;
    logic [WIDTH-2:0] rem_sum_i;
    logic [WIDTH-2:0] rem_carry_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [QUOT_W-1:0] quot_o;
    logic [WIDTH-2:0] rem_o;
    logic             rem_zero_o;
    logic             digit_err_o;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [3:0][1:0] digs;   // digs[3] is applied first
        logic [3:0]      gap;    // idle cycles before each digit
        logic [6:0]      sum;
        logic [6:0]      carry;
        logic [3:0]      e_quot;
        logic [6:0]      e_rem;
        logic            e_zero;
        logic            e_err;
    } vec_t;

    vec_t vecs[6];

    radix_2_srt_rem_resolve #(
        .WIDTH    (WIDTH),
        .QUOT_W   (QUOT_W),
        .ITER_NUM (ITER_NUM)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_valid_i (start_valid_i),
        .start_ready_o (start_ready_o),
        .divisor_i     (divisor_i),
        .digit_valid_i (digit_valid_i),
        .digit_ready_o (digit_ready_o),
        .q_digit_i     (q_digit_i),
        .rem_sum_i     (rem_sum_i),
        .rem_carry_i   (rem_carry_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .quot_o        (quot_o),
        .rem_o         (rem_o),
        .rem_zero_o    (rem_zero_o),
        .digit_err_o   (digit_err_o)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(logic [3:0][1:0] digs, logic [3:0] gap,
                                logic [6:0] sum, logic [6:0] carry,
                                logic [3:0] e_quot, logic [6:0] e_rem,
                                logic e_zero, logic e_err);
        vec_t v;
        v.digs   = digs;
        v.gap    = gap;
        v.sum    = sum;
        v.carry  = carry;
        v.e_quot = e_quot;
        v.e_rem  = e_rem;
        v.e_zero = e_zero;
        v.e_err  = e_err;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic start_op();
        int w;
        w = 0;
        while (!start_ready_o && w < 20) begin
            tick();
            w++;
        end
        check("start_ready_before_start", 32'(start_ready_o), 32'd1);
        start_valid_i = 1'b1;
        divisor_i     = 7'h10;
        tick();
        start_valid_i = 1'b0;
        divisor_i     = 7'($urandom_range(0, 127));
    endtask

    task automatic feed_digit(logic [1:0] d, bit last, logic [6:0] sum, logic [6:0] carry);
        check("digit_ready", 32'(digit_ready_o), 32'd1);
        digit_valid_i = 1'b1;
        q_digit_i     = d;
        rem_sum_i     = last ? sum   : 7'($urandom_range(0, 127));
        rem_carry_i   = last ? carry : 7'($urandom_range(0, 127));
        tick();
        digit_valid_i = 1'b0;
        q_digit_i     = 2'($urandom_range(0, 3));
        rem_sum_i     = 7'($urandom_range(0, 127));
        rem_carry_i   = 7'($urandom_range(0, 127));
    endtask

    // Runs one operation up to DONE and checks latency and the result.
    task automatic run_op(vec_t v, string tag);
        int lat;
        start_op();
        for (int i = 3; i >= 0; i--) begin
            for (int g = 0; g < int'(v.gap); g++) begin
                tick();
            end
            feed_digit(v.digs[i], (i == 0), v.sum, v.carry);
        end
        lat = 0;
        while (!out_valid_o && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd2);
        check({tag, "_quot"}, 32'(quot_o), 32'(v.e_quot));
        check({tag, "_rem"}, 32'(rem_o), 32'(v.e_rem));
        check({tag, "_rem_zero"}, 32'(rem_zero_o), 32'(v.e_zero));
        check({tag, "_digit_err"}, 32'(digit_err_o), 32'(v.e_err));
    endtask

    task automatic release_out(string tag);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check({tag, "_valid_dropped"}, 32'(out_valid_o), 32'd0);
        check({tag, "_back_idle"}, 32'(start_ready_o), 32'd1);
    endtask

    initial begin
        start_valid_i = 1'b0;
        divisor_i     = '0;
        digit_valid_i = 1'b0;
        q_digit_i     = 2'b00;
        rem_sum_i     = '0;
        rem_carry_i   = '0;
        out_ready_i   = 1'b0;
        rst           = 1'b1;

        //                digits          gap  sum    carry  quot     rem    zero err
        vecs[0] = mk({DP, DZ, DN, DP}, 4'd0, 7'h05, 7'h7C, 4'b0111, 7'h01, 1'b0, 1'b0);
        vecs[1] = mk({DP, DZ, DN, DP}, 4'd0, 7'h05, 7'h78, 4'b0110, 7'h0D, 1'b0, 1'b0);
        vecs[2] = mk({DP, DZ, DN, DP}, 4'd0, 7'h40, 7'h40, 4'b0111, 7'h00, 1'b1, 1'b0);
        vecs[3] = mk({DP, DX, DZ, DP}, 4'd2, 7'h05, 7'h7C, 4'b1001, 7'h01, 1'b0, 1'b1);
        vecs[4] = mk({DN, DN, DN, DN}, 4'd1, 7'h7F, 7'h00, 4'b0000, 7'h0F, 1'b0, 1'b0);
        vecs[5] = mk({DP, DP, DP, DP}, 4'd0, 7'h3F, 7'h00, 4'b1111, 7'h3F, 1'b0, 1'b0);

        repeat (3) tick();
        rst = 1'b0;

        // Reset state.
        check("rst_start_ready", 32'(start_ready_o), 32'd1);
        check("rst_digit_ready", 32'(digit_ready_o), 32'd0);
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_quot", 32'(quot_o), 32'd0);
        check("rst_rem", 32'(rem_o), 32'd0);
        check("rst_rem_zero", 32'(rem_zero_o), 32'd0);
        check("rst_digit_err", 32'(digit_err_o), 32'd0);

        // Table-driven operations.
        for (int k = 0; k < 6; k++) begin
            run_op(vecs[k], $sformatf("vec%0d", k));
            release_out($sformatf("vec%0d", k));
        end

        // Backpressure in DONE with start pulses that must be ignored.
        run_op(vecs[1], "bp");
        for (int c = 0; c < 5; c++) begin
            start_valid_i = (c % 2 == 0);
            tick();
            check("bp_out_valid", 32'(out_valid_o), 32'd1);
            check("bp_quot_stable", 32'(quot_o), 32'(4'b0110));
            check("bp_rem_stable", 32'(rem_o), 32'(7'h0D));
            check("bp_start_ready", 32'(start_ready_o), 32'd0);
        end
        start_valid_i = 1'b0;
        release_out("bp");
        tick();
        check("bp_no_spurious_start", 32'(digit_ready_o), 32'd0);

        // Reset in the middle of an operation.
        start_op();
        feed_digit(DP, 1'b0, 7'h00, 7'h00);
        feed_digit(DZ, 1'b0, 7'h00, 7'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_start_ready", 32'(start_ready_o), 32'd1);
        check("midrst_out_valid", 32'(out_valid_o), 32'd0);
        check("midrst_digit_ready", 32'(digit_ready_o), 32'd0);
        check("midrst_quot", 32'(quot_o), 32'd0);
        check("midrst_rem", 32'(rem_o), 32'd0);
        repeat (4) tick();
        check("midrst_no_result", 32'(out_valid_o), 32'd0);
        run_op(vecs[1], "after_rst");
        release_out("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

endmodule
